md_seq: RTL
===========

# md_seq

Iterative RV32M multiply/divide sequencer in the EX stage. When EX decodes an OP-type instruction with funct7 = 0000001, this block takes rs1/rs2 and runs a 32-iteration shift-add multiply or restoring divide. While it runs it holds the pipeline with `ex_stall`, and it presents the 32-bit result in the cycle it releases the stall. The EX writeback mux selects `md_result` for these instructions.

## Interface
Parameters:
- `XLEN`, 32, operand/result width. Only 32 is supported.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  EX holds a valid M-extension instruction; held high until the pipeline advances
- `func3`  in  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `op_a`  in  XLEN  rs1 value
- `op_b`  in  XLEN  rs2 value
- `flush`  in  1  EX is being killed (branch/jump taken downstream or trap)
- `ex_stall`  out  1  freeze IF/ID/EX
- `busy`  out  1  sequencer is in CALC or FIX
- `done`  out  1  one-cycle pulse: `md_result` is valid
- `md_result`  out  XLEN  result; holds its value until the next accepted start

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - `start & ~flush` accepts the operation. It latches `func3` and the operand magnitudes, plus the sign flags below.
  - Sign flags: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM.
  - Normal case: go to CALC with `cnt = 0`.
- **Special cases (detected in IDLE, bypass CALC, go straight to DONE):**
  - DIV/DIVU by zero: result 0xFFFFFFFF.
  - REM/REMU by zero: result `op_a`.
  - DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF: result 0.
- **CALC:** one iteration per cycle; `cnt` is 5 bits.
  - Multiply: 64-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: 33-bit partial remainder, restoring subtract, quotient bit shifted in.
  - After the iteration with `cnt == 31`, go to FIX.
- **FIX:**
  - Multiply: negate the 64-bit product if the effective signs differ.
  - Divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Select the result: MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32]; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register the result into `md_result` and go to DONE.
- **DONE:** `done = 1`, `ex_stall = 0`. The pipeline advances at the end of this cycle. `start` is still high here and is ignored. Go to IDLE.
- **Flush:** `flush` in any state forces IDLE on the next edge. No `done` is produced and `md_result` is unchanged. If `start` and `flush` arrive in the same IDLE cycle, flush wins and nothing is accepted.
- **Reset:** `rst` at any cycle, including mid-CALC, returns to IDLE and clears `cnt` and the accumulators.
- **Arithmetic:**
  - All negations are two's complement at full internal width.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
  - No overflow traps.

## Timing
- **Reset values:** state IDLE, `ex_stall = 0`, `busy = 0`, `done = 0`, `md_result = 0`.
- **`ex_stall`** is combinational: `(IDLE & start & ~flush) | CALC | FIX`. The stall is asserted in the same cycle EX presents the instruction.
- **`busy`** is registered: high exactly while in CALC or FIX.
- **Normal latency:** start accepted at cycle 0 (IDLE); CALC in cycles 1–32; FIX in cycle 33; DONE (`done = 1`) in cycle 34. That gives 34 stall cycles.
- **Special-case latency:** start accepted at cycle 0, DONE in cycle 1, one stall cycle.
- **Back-to-back:** the next M-op can be accepted in the cycle after DONE.
- **Throughput:** one operation in flight.

## Structure
- **Shared header:** M-op func3 codes (`FNC_MUL`..`FNC_REMU`), the funct7 constant `FNC7_MULDIV`, and the state encodings (`MD_IDLE`, `MD_CALC`, `MD_FIX`, `MD_DONE`). These go in the shared header next to the existing opcode/ctrl defines.
- **Sub-module `md_datapath`:** accumulator, partial-remainder and negate logic, controlled by a step/fix/load interface.
- **FSM, counter, special-case detect and stall logic** stay in `md_seq`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `md_result` 0xFFFFFFEB; `done` in cycle 34; `ex_stall` high for cycles 0–33.
- 0xFFFFFFFF × 0xFFFFFFFF → MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 7 / 2 → 3; REMU 7 / 2 → 1.
- Special cases, each with `done` in cycle 1:
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Flush in cycle 10 of CALC → IDLE the next cycle, `busy` low, no `done`, `md_result` keeps its previous value. Then start DIVU 100 / 7 immediately → 14 with `done` 34 cycles later.
- Reset:
  - `rst` asserted mid-CALC → all outputs at reset values the next cycle.
  - `start` held through DONE → exactly one `done` pulse; the next operation is accepted only after `start` re-qualifies in IDLE.

Source files
------------

// File: rtl/md_seq_pkg.sv
// Shared M-extension definitions: func3/funct7 codes, sequencer states and
// the magnitude / conditional-negate helpers used by the multiply/divide unit.
package md_seq_pkg;

  localparam logic [2:0] FNC_MUL    = 3'd0;
  localparam logic [2:0] FNC_MULH   = 3'd1;
  localparam logic [2:0] FNC_MULHSU = 3'd2;
  localparam logic [2:0] FNC_MULHU  = 3'd3;
  localparam logic [2:0] FNC_DIV    = 3'd4;
  localparam logic [2:0] FNC_DIVU   = 3'd5;
  localparam logic [2:0] FNC_REM    = 3'd6;
  localparam logic [2:0] FNC_REMU   = 3'd7;

  localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // 0x80000000 maps onto itself and is then read as an unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn & v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_seq_datapath.sv
// Multiply/divide datapath: shift-add product accumulator, restoring-divide
// partial remainder and the sign fix-up that produces the selected result.
module md_datapath
  import md_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic        neg_res,
  input  logic        neg_rem,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  // acc_r holds {product_hi, product_lo} for multiply; its low half is the
  // dividend shifting out / quotient shifting in for divide.
  logic [63:0] acc_r;
  logic [32:0] rem_r;
  logic [31:0] b_r;
  logic        is_div_r;
  logic        neg_res_r;
  logic        neg_rem_r;

  logic [32:0] sum_s;
  logic [33:0] shifted_s;
  logic [33:0] diff_s;
  logic        ge_s;
  logic [63:0] acc_next_s;
  logic [32:0] rem_next_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // One shift-add or restoring-subtract iteration.
  always_comb begin
    sum_s      = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, b_r} : 33'd0);
    shifted_s  = {rem_r, acc_r[31]};
    diff_s     = shifted_s - {2'b00, b_r};
    ge_s       = ~diff_s[33];
    acc_next_s = acc_r;
    rem_next_s = rem_r;
    if (is_div_r) begin
      acc_next_s = {acc_r[63:32], acc_r[30:0], ge_s};
      rem_next_s = ge_s ? diff_s[32:0] : shifted_s[32:0];
    end else begin
      acc_next_s = {sum_s, acc_r[31:1]};
      rem_next_s = rem_r;
    end
  end

  // Operand load and per-cycle iteration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= 64'd0;
      rem_r     <= 33'd0;
      b_r       <= 32'd0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (load) begin
      acc_r     <= {32'd0, a_mag};
      rem_r     <= 33'd0;
      b_r       <= b_mag;
      is_div_r  <= is_div;
      neg_res_r <= neg_res;
      neg_rem_r <= neg_rem;
    end else if (step) begin
      acc_r <= acc_next_s;
      rem_r <= rem_next_s;
    end
  end

  // Sign fix-up and result select, consumed by the sequencer in FIX.
  always_comb begin
    prod_s = cneg64(acc_r, neg_res_r);
    quo_s  = cneg32(acc_r[31:0], neg_res_r);
    rem_s  = cneg32(rem_r[31:0], neg_rem_r);
    case (func3)
      FNC_MUL:                        result = prod_s[31:0];
      FNC_MULH, FNC_MULHSU, FNC_MULHU: result = prod_s[63:32];
      FNC_DIV, FNC_DIVU:              result = quo_s;
      FNC_REM, FNC_REMU:              result = rem_s;
      default:                        result = prod_s[31:0];
    endcase
  end

endmodule

// File: rtl/md_seq.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, special-case
// detection and pipeline stall around the md_datapath iteration engine.
module md_seq
  import md_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            ex_stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] md_result
);

  md_state_e   state_r;
  logic [4:0]  cnt_r;
  logic [2:0]  func3_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] md_result_r;

  logic        a_sgn_s;
  logic        b_sgn_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic        b_zero_s;
  logic        ovf_s;
  logic        special_s;
  logic [31:0] special_res_s;
  logic        accept_s;
  logic        load_s;
  logic        step_s;
  logic [31:0] dp_result_s;

  // Operand signedness per func3.
  always_comb begin
    case (func3)
      FNC_MULH, FNC_DIV, FNC_REM: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      FNC_MULHSU:                 begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
      default:                    begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
    endcase
  end

  assign a_neg_s  = a_sgn_s & op_a[31];
  assign b_neg_s  = b_sgn_s & op_b[31];
  assign b_zero_s = (op_b == 32'd0);
  assign ovf_s    = (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);

  // Divide-by-zero and signed-overflow results that skip the iteration.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = 32'd0;
    case (func3)
      FNC_DIV: begin
        if (b_zero_s) begin
          special_s = 1'b1; special_res_s = 32'hFFFF_FFFF;
        end else if (ovf_s) begin
          special_s = 1'b1; special_res_s = 32'h8000_0000;
        end else begin
          special_s = 1'b0; special_res_s = 32'd0;
        end
      end
      FNC_REM: begin
        if (b_zero_s) begin
          special_s = 1'b1; special_res_s = op_a;
        end else if (ovf_s) begin
          special_s = 1'b1; special_res_s = 32'd0;
        end else begin
          special_s = 1'b0; special_res_s = 32'd0;
        end
      end
      FNC_DIVU: begin
        special_s     = b_zero_s;
        special_res_s = 32'hFFFF_FFFF;
      end
      FNC_REMU: begin
        special_s     = b_zero_s;
        special_res_s = op_a;
      end
      default: begin
        special_s     = 1'b0;
        special_res_s = 32'd0;
      end
    endcase
  end

  assign accept_s = (state_r == MD_IDLE) & start & ~flush;
  assign load_s   = accept_s & ~special_s;
  assign step_s   = (state_r == MD_CALC) & ~flush;

  md_datapath u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .step    (step_s),
    .is_div  (func3[2]),
    .neg_res (a_neg_s ^ b_neg_s),
    .neg_rem (a_neg_s),
    .a_mag   (mag32(op_a, a_sgn_s)),
    .b_mag   (mag32(op_b, b_sgn_s)),
    .func3   (func3_r),
    .result  (dp_result_s)
  );

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= MD_IDLE;
      cnt_r       <= 5'd0;
      func3_r     <= 3'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      md_result_r <= 32'd0;
    end else if (flush) begin
      state_r <= MD_IDLE;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            func3_r <= func3;
            cnt_r   <= 5'd0;
            if (special_s) begin
              md_result_r <= special_res_s;
              done_r      <= 1'b1;
              state_r     <= MD_DONE;
            end else begin
              busy_r  <= 1'b1;
              state_r <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= MD_FIX;
          end
        end
        MD_FIX: begin
          md_result_r <= dp_result_s;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          state_r     <= MD_DONE;
        end
        MD_DONE: begin
          done_r  <= 1'b0;
          state_r <= MD_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= MD_IDLE;
        end
      endcase
    end
  end

  assign ex_stall  = accept_s | (state_r == MD_CALC) | (state_r == MD_FIX);
  assign busy      = busy_r;
  assign done      = done_r;
  assign md_result = md_result_r;

endmodule
